// File: rtl/mem_stage.sv
// +-----------------------------------------------------------------------+
// | mem_stage: memory-access pipeline stage, LOAD/STORE over req/ack port  |
// | Optional: define MEM_TIMEOUT_EN for the d_ack watchdog and mem_err     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

`ifndef LOAD
`define LOAD 5'b10000
`endif
`ifndef EXEC
`define EXEC 1'b1
`endif

module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              state,
  input  logic [DATA_W-1:0] mem_ir,
  input  logic [DATA_W-1:0] reg_C,
  input  logic              dw,
  input  logic [DATA_W-1:0] smdr1,
  output logic [DATA_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_wdata,
  output logic              d_we,
  output logic              d_req,
  input  logic              d_ack,
  input  logic [DATA_W-1:0] d_rdata,
  output logic [DATA_W-1:0] wb_ir,
  output logic [DATA_W-1:0] reg_C1,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]        fsm_q, fsm_d;
  logic              exec_cyc, mem_op;
  logic              capture, accept, abort, pend_set, timeout_hit;
  logic [DATA_W-1:0] ir_q, c_q, pend_data, rdata_sel;
  logic              dw_q, ack_pend;

  assign exec_cyc  = (state == `EXEC);
  assign mem_op    = (mem_ir[DATA_W-1 -: 5] == `LOAD) || dw;
  assign rdata_sel = ack_pend ? pend_data : d_rdata;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (capture)
        wait_cnt <= '0;
      else if (fsm_q == S_WAIT && exec_cyc && !accept)
        wait_cnt <= wait_cnt + 1'b1;
      if (abort)
        mem_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
  assign timeout_hit    = 1'b0;
  assign mem_err        = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fsm_q <= S_IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (capture) fsm_d = S_WAIT;
      S_WAIT:  if (accept || abort) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // An ack arriving on a stalled cycle is parked in ack_pend so it is not lost.
  always_comb begin
    capture  = 1'b0;
    accept   = 1'b0;
    abort    = 1'b0;
    pend_set = 1'b0;
    case (fsm_q)
      S_IDLE: capture = exec_cyc && mem_op;
      S_WAIT: begin
        accept   = exec_cyc && (d_ack || ack_pend);
        abort    = exec_cyc && !accept && timeout_hit;
        pend_set = !exec_cyc && d_ack && !ack_pend;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_ir     <= '0;
      reg_C1    <= '0;
      d_addr    <= '0;
      d_wdata   <= '0;
      d_we      <= 1'b0;
      d_req     <= 1'b0;
      mem_busy  <= 1'b0;
      ir_q      <= '0;
      c_q       <= '0;
      dw_q      <= 1'b0;
      ack_pend  <= 1'b0;
      pend_data <= '0;
    end else begin
      if (fsm_q == S_IDLE && exec_cyc) begin
        if (mem_op) begin
          ir_q     <= mem_ir;
          c_q      <= reg_C;
          dw_q     <= dw;
          d_addr   <= reg_C;
          d_wdata  <= smdr1;
          d_we     <= dw;
          d_req    <= 1'b1;
          mem_busy <= 1'b1;
          wb_ir    <= '0;
        end else begin
          wb_ir  <= mem_ir;
          reg_C1 <= reg_C;
        end
      end
      if (fsm_q == S_WAIT && exec_cyc)
        wb_ir <= '0;
      if (pend_set) begin
        ack_pend  <= 1'b1;
        pend_data <= d_rdata;
      end
      if (accept) begin
        wb_ir    <= ir_q;
        reg_C1   <= dw_q ? c_q : rdata_sel;
        d_req    <= 1'b0;
        d_we     <= 1'b0;
        mem_busy <= 1'b0;
        ack_pend <= 1'b0;
      end
      if (abort) begin
        wb_ir    <= '0;
        d_req    <= 1'b0;
        d_we     <= 1'b0;
        mem_busy <= 1'b0;
        ack_pend <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table for single-cycle ops plus
// hand sequences for LOAD/STORE, stalled ack, reset abort and timeout.
`default_nettype none

module tb_mem_stage;

  localparam logic [15:0] LOAD_IR = 16'h8005;  // opcode 5'b10000

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        state = 1'b0;
  logic [15:0] mem_ir = '0, reg_C = '0, smdr1 = '0, d_rdata = '0;
  logic        dw = 1'b0, d_ack = 1'b0;
  logic [15:0] d_addr, d_wdata, wb_ir, reg_C1;
  logic        d_we, d_req, mem_busy, mem_err;

  int compared = 0;
  int mismatched = 0;

  mem_stage #(.DATA_W(16), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .state(state), .mem_ir(mem_ir),
    .reg_C(reg_C), .dw(dw), .smdr1(smdr1), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_we(d_we), .d_req(d_req), .d_ack(d_ack),
    .d_rdata(d_rdata), .wb_ir(wb_ir), .reg_C1(reg_C1),
    .mem_busy(mem_busy), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        st;
    logic [15:0] ir;
    logic [15:0] c;
    logic        ack;
    logic [15:0] exp_wb;
    logic [15:0] exp_c1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk16({tag, " wb_ir"}, wb_ir, 16'h0);
    chk16({tag, " reg_C1"}, reg_C1, 16'h0);
    chk16({tag, " d_addr"}, d_addr, 16'h0);
    chk16({tag, " d_wdata"}, d_wdata, 16'h0);
    chk1({tag, " d_we"}, d_we, 1'b0);
    chk1({tag, " d_req"}, d_req, 1'b0);
    chk1({tag, " mem_busy"}, mem_busy, 1'b0);
    chk1({tag, " mem_err"}, mem_err, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h4123, 16'h00FF, 1'b0, 16'h4123, 16'h00FF};
    vecs[1] = '{1'b0, 16'h5555, 16'h1111, 1'b0, 16'h4123, 16'h00FF};
    vecs[2] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 16'hFFFF};
    vecs[4] = '{1'b1, 16'hF800, 16'h8000, 1'b0, 16'hF800, 16'h8000};
    vecs[5] = '{1'b1, 16'h8800, 16'h1234, 1'b0, 16'h8800, 16'h1234};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h8800, 16'h1234};
    vecs[7] = '{1'b1, 16'h2345, 16'h0042, 1'b1, 16'h2345, 16'h0042};

    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // Single-cycle, non-memory vectors
    for (int i = 0; i < 8; i++) begin
      state  = vecs[i].st;
      mem_ir = vecs[i].ir;
      reg_C  = vecs[i].c;
      d_ack  = vecs[i].ack;
      tick();
      chk16($sformatf("vec%0d wb_ir", i), wb_ir, vecs[i].exp_wb);
      chk16($sformatf("vec%0d reg_C1", i), reg_C1, vecs[i].exp_c1);
      chk1($sformatf("vec%0d d_req", i), d_req, 1'b0);
      chk1($sformatf("vec%0d mem_busy", i), mem_busy, 1'b0);
    end
    d_ack = 1'b0;

    // LOAD, ack sampled on the fourth WAIT cycle
    state = 1'b1; mem_ir = LOAD_IR; reg_C = 16'h0010; dw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1($sformatf("load busy%0d", i), mem_busy, 1'b1);
      chk1($sformatf("load req%0d", i), d_req, 1'b1);
      chk16($sformatf("load wb_ir%0d", i), wb_ir, 16'h0);
    end
    chk16("load d_addr", d_addr, 16'h0010);
    chk1("load d_we", d_we, 1'b0);
    d_ack = 1'b1; d_rdata = 16'hBEEF; mem_ir = 16'h0000; reg_C = 16'h0000;
    tick();
    d_ack = 1'b0; d_rdata = 16'h0000;
    chk16("load wb_ir done", wb_ir, LOAD_IR);
    chk16("load reg_C1", reg_C1, 16'hBEEF);
    chk1("load d_req done", d_req, 1'b0);
    chk1("load busy done", mem_busy, 1'b0);

    // STORE, ack one cycle after request
    mem_ir = 16'h6000; dw = 1'b1; reg_C = 16'h0020; smdr1 = 16'h1234;
    tick();
    chk1("store d_we", d_we, 1'b1);
    chk16("store d_wdata", d_wdata, 16'h1234);
    chk16("store d_addr", d_addr, 16'h0020);
    chk1("store d_req", d_req, 1'b1);
    d_ack = 1'b1; dw = 1'b0; mem_ir = 16'h0000; reg_C = 16'h0000; smdr1 = 16'h0000;
    tick();
    d_ack = 1'b0;
    chk16("store reg_C1", reg_C1, 16'h0020);
    chk16("store wb_ir", wb_ir, 16'h6000);
    chk1("store d_req done", d_req, 1'b0);
    chk1("store d_we done", d_we, 1'b0);

    // LOAD whose ack arrives while the CPU is stalled
    mem_ir = LOAD_IR; reg_C = 16'h0040;
    tick();
    chk1("pend req", d_req, 1'b1);
    state = 1'b0; d_ack = 1'b1; d_rdata = 16'h00AA;
    tick();
    d_ack = 1'b0; d_rdata = 16'hFFFF;
    chk1("pend busy1", mem_busy, 1'b1);
    tick();
    chk1("pend busy2", mem_busy, 1'b1);
    chk1("pend req2", d_req, 1'b1);
    chk16("pend wb_ir", wb_ir, 16'h0);
    state = 1'b1; mem_ir = 16'h0000; reg_C = 16'h0000;
    tick();
    chk16("pend reg_C1", reg_C1, 16'h00AA);
    chk16("pend wb_ir done", wb_ir, LOAD_IR);
    chk1("pend busy done", mem_busy, 1'b0);
    d_rdata = 16'h0000;

`ifdef MEM_TIMEOUT_EN
    // LOAD with no ack: watchdog aborts after 4 exec WAIT cycles
    chk1("tmo err before", mem_err, 1'b0);
    mem_ir = LOAD_IR; reg_C = 16'h0030;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("tmo busy%0d", i), mem_busy, 1'b1);
    end
    mem_ir = 16'h0000; reg_C = 16'h0000;
    tick();
    chk1("tmo d_req", d_req, 1'b0);
    chk1("tmo busy", mem_busy, 1'b0);
    chk1("tmo mem_err", mem_err, 1'b1);
    chk16("tmo wb_ir", wb_ir, 16'h0);
    chk16("tmo reg_C1 hold", reg_C1, 16'h00AA);
    mem_ir = 16'h4123; reg_C = 16'h00FF;
    tick();
    chk1("tmo err sticky", mem_err, 1'b1);
    chk16("tmo next wb_ir", wb_ir, 16'h4123);
`else
    chk1("no-tmo mem_err", mem_err, 1'b0);
`endif

    // Reset in the middle of WAIT aborts asynchronously
    mem_ir = LOAD_IR; reg_C = 16'h0050;
    tick();
    chk1("rst pre d_req", d_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("rst mid");
    @(negedge clock);
    reset = 1'b1;
    mem_ir = 16'h4123; reg_C = 16'h00FF;
    tick();
    chk16("rst add wb_ir", wb_ir, 16'h4123);
    chk16("rst add reg_C1", reg_C1, 16'h00FF);
    chk1("rst add d_req", d_req, 1'b0);
    chk1("rst add mem_err", mem_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
